// File: rtl/edge_pkg.sv
// Shared constants for the multi-channel edge detector/counter.
package edge_pkg;

    localparam int unsigned DEF_CHANNELS    = 4;
    localparam int unsigned DEF_CNT_W       = 8;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_DEB_CYCLES  = 4;

    // Detection stays suppressed for SYNC_STAGES + ARM_EXTRA cycles after reset release.
    localparam int unsigned ARM_EXTRA = 1;
    localparam int unsigned ARM_W     = 3;
    localparam int unsigned DEB_W     = 8;

    // Counter overflow behaviour, selected by SATURATE.
    localparam int unsigned WRAP = 0;
    localparam int unsigned SAT  = 1;

endpackage

// File: rtl/edge_chan.sv
// One monitored line: synchroniser, optional debounce filter (EDGE_DEBOUNCE_EN),
// registered edge detector and rising/falling edge counters.
module edge_chan
    import edge_pkg::*;
#(
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
`ifdef EDGE_DEBOUNCE_EN
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES,
`endif
    parameter int unsigned SATURATE    = WRAP
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig,
    input  logic             armed,
    input  logic             enable,
    input  logic             clear,
    output logic             pos_pulse,
    output logic             neg_pulse,
    output logic [CNT_W-1:0] pos_count,
    output logic [CNT_W-1:0] neg_count,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   level;
    logic                   prev_q;
    logic                   rise;
    logic                   fall;
    logic                   pos_pulse_q;
    logic                   neg_pulse_q;
    logic [CNT_W-1:0]       pos_q, pos_d;
    logic [CNT_W-1:0]       neg_q, neg_d;
    logic                   ovf_q, ovf_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig};
        end
    end

`ifdef EDGE_DEBOUNCE_EN
    logic [DEB_W-1:0] deb_q, deb_d;
    logic             filt_q, filt_d;

    // The filtered level follows only after DEB_CYCLES consecutive cycles at a new value.
    always_comb begin
        deb_d  = '0;
        filt_d = filt_q;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (deb_q + DEB_W'(1) == DEB_W'(DEB_CYCLES)) begin
                filt_d = sync_q[SYNC_STAGES-1];
            end else begin
                deb_d = deb_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            deb_q  <= '0;
            filt_q <= 1'b0;
        end else begin
            deb_q  <= deb_d;
            filt_q <= filt_d;
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[SYNC_STAGES-1];
`endif

    // prev keeps tracking level while disarmed so no stale edge fires at arm time.
    assign rise = armed & level & ~prev_q;
    assign fall = armed & ~level & prev_q;

    always_comb begin
        pos_d = clear ? '0 : pos_q;
        neg_d = clear ? '0 : neg_q;
        ovf_d = clear ? 1'b0 : ovf_q;
        if (enable && rise) begin
            if (pos_d == CNT_MAX) begin
                ovf_d = 1'b1;
                pos_d = (SATURATE == SAT) ? CNT_MAX : '0;
            end else begin
                pos_d = pos_d + CNT_W'(1);
            end
        end
        if (enable && fall) begin
            if (neg_d == CNT_MAX) begin
                ovf_d = 1'b1;
                neg_d = (SATURATE == SAT) ? CNT_MAX : '0;
            end else begin
                neg_d = neg_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q      <= 1'b0;
            pos_pulse_q <= 1'b0;
            neg_pulse_q <= 1'b0;
            pos_q       <= '0;
            neg_q       <= '0;
            ovf_q       <= 1'b0;
        end else begin
            prev_q      <= level;
            pos_pulse_q <= rise;
            neg_pulse_q <= fall;
            pos_q       <= pos_d;
            neg_q       <= neg_d;
            ovf_q       <= ovf_d;
        end
    end

    assign pos_pulse = pos_pulse_q;
    assign neg_pulse = neg_pulse_q;
    assign pos_count = pos_q;
    assign neg_count = neg_q;
    assign overflow  = ovf_q;

endmodule

// File: rtl/edge_counter_multi.sv
// Multi-channel edge detector/counter with a shared post-reset arming window.
// Define EDGE_DEBOUNCE_EN to insert a DEB_CYCLES debounce filter in every channel.
module edge_counter_multi
    import edge_pkg::*;
#(
    parameter int unsigned CHANNELS    = DEF_CHANNELS,
    parameter int unsigned CNT_W       = DEF_CNT_W,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned SATURATE    = WRAP,
    parameter int unsigned DEB_CYCLES  = DEF_DEB_CYCLES
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       sig_in,
    input  logic                      enable,
    input  logic [CHANNELS-1:0]       clear,
    output logic [CHANNELS-1:0]       pos_pulse,
    output logic [CHANNELS-1:0]       neg_pulse,
    output logic [CHANNELS*CNT_W-1:0] pos_count,
    output logic [CHANNELS*CNT_W-1:0] neg_count,
    output logic [CHANNELS-1:0]       overflow
);

    localparam logic [ARM_W-1:0] ARM_LEN = ARM_W'(SYNC_STAGES + ARM_EXTRA);

    if (CHANNELS < 1 || CHANNELS > 32 || CNT_W < 2 || CNT_W > 32 ||
        SYNC_STAGES < 2 || SYNC_STAGES > 4 || SATURATE > SAT ||
        DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_param_err
        $error("edge_counter_multi: parameter out of range");
    end

    logic [ARM_W-1:0] arm_q;
    logic             armed;

    always_ff @(posedge clk) begin
        if (reset) begin
            arm_q <= ARM_LEN;
        end else if (arm_q != '0) begin
            arm_q <= arm_q - ARM_W'(1);
        end
    end

    assign armed = (arm_q == '0);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        edge_chan #(
            .CNT_W       (CNT_W),
            .SYNC_STAGES (SYNC_STAGES),
`ifdef EDGE_DEBOUNCE_EN
            .DEB_CYCLES  (DEB_CYCLES),
`endif
            .SATURATE    (SATURATE)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .sig       (sig_in[i]),
            .armed     (armed),
            .enable    (enable),
            .clear     (clear[i]),
            .pos_pulse (pos_pulse[i]),
            .neg_pulse (neg_pulse[i]),
            .pos_count (pos_count[i*CNT_W +: CNT_W]),
            .neg_count (neg_count[i*CNT_W +: CNT_W]),
            .overflow  (overflow[i])
        );
    end

endmodule

// File: doc/edge_counter_multi.md
Name: edge_counter_multi

Overview:
- Parametrised successor to the single edge detector/counter.
- Monitors CHANNELS asynchronous input lines, synchronises each one, and emits single-cycle rising/falling-edge pulses.
- Keeps per-channel rising and falling edge counters of CNT_W bits, with wrap or saturate mode, sticky overflow flags and per-channel clear.
- Sits at the boundary between external/asynchronous status lines and the register/monitor logic.

Parameters:
- CHANNELS, 4: number of independent input lines (1..32).
- CNT_W, 8: width of each edge counter (2..32).
- SYNC_STAGES, 2: synchroniser flops per channel (2..4).
- SATURATE, 0: 0 = counters wrap to 0 after max; 1 = counters hold at 2^CNT_W-1.
- DEB_CYCLES, 4: stable-cycle count used only when EDGE_DEBOUNCE_EN is defined (1..255).

Ports:
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sig_in  in  CHANNELS  asynchronous monitored lines, bit i = channel i.
- enable  in  1  1 = counters update; 0 = counters hold, pulses still produced.
- clear  in  CHANNELS  per-channel synchronous clear of both counters and the overflow flag.
- pos_pulse  out  CHANNELS  one-cycle pulse per detected rising edge.
- neg_pulse  out  CHANNELS  one-cycle pulse per detected falling edge.
- pos_count  out  CHANNELS*CNT_W  packed rising-edge counts; channel i occupies [i*CNT_W +: CNT_W].
- neg_count  out  CHANNELS*CNT_W  packed falling-edge counts, same packing.
- overflow  out  CHANNELS  sticky flag: either counter of the channel hit max and received another edge.

Behaviour:
- Reset (synchronous, active-high): all synchroniser flops, previous-value flops, pulses, counts and overflow go to 0; the arm counter is loaded.
- Arming:
  - After reset deasserts, edge detection is suppressed for SYNC_STAGES+1 cycles, so an input already high does not produce a false rising edge.
  - During arming, the previous-value flop tracks the synchronised value.
- Synchronisation: sig_in[i] → SYNC_STAGES flops → s[i]; prev[i] holds s[i] delayed one cycle.
- Detection: rise = s & ~prev, fall = ~s & prev. Pulses are registered.
- Latency: a level change first sampled at edge k gives a pulse high during the cycle after edge k+SYNC_STAGES, for exactly one cycle.
- Counter update: on the same edge that asserts the pulse, the matching count increments if enable=1, so pulse and new count are visible together.
- Back-to-back toggles (input changes every cycle) produce a pulse every cycle, alternating pos/neg. Nothing is dropped.
- Wrap mode (SATURATE=0): max+1 → 0 and overflow[i] is set.
- Saturate mode (SATURATE=1): count stays at max and overflow[i] is set.
- Clear:
  - clear[i]=1 zeros pos_count[i], neg_count[i] and overflow[i] next cycle.
  - If an edge is counted in the same cycle (enable=1), the result is 1 in the counter for that edge, 0 in the other, and overflow=0.
  - clear does not affect pulses or the synchroniser.
- enable=0: counts and overflow hold; pulses and clear still operate.
- Channels are fully independent. Simultaneous edges on any set of channels are all counted.
- Reset mid-operation: pulses in flight are discarded and arming restarts.

Optional Feature:
- Macro: EDGE_DEBOUNCE_EN.
- Defined:
  - A per-channel debounce stage sits between the synchroniser and the detector.
  - The filtered level changes only after s[i] has held a new value for DEB_CYCLES consecutive cycles.
  - Latency grows by DEB_CYCLES cycles.
  - Pulses shorter than DEB_CYCLES cycles produce no edges.
  - The debounce counter resets to 0 and the filtered level resets to 0.
- Undefined: no filter logic, DEB_CYCLES is ignored, and latency is as above.

Decomposition:
- Package edge_pkg: function-free constants only, namely default widths, arm length expression SYNC_STAGES+1, and the SATURATE mode encodings WRAP=0 / SAT=1.
- Sub-module edge_chan: one channel, i.e. synchroniser, optional debounce, detector and two counters.
- Top level instantiates edge_chan CHANNELS times in a generate loop, packs the counts and shares the arm counter.

Test Plan:
- Parameters CHANNELS=4, CNT_W=8, SYNC_STAGES=2, no debounce. Hold sig_in=4'b1111 through reset, release reset, wait 10 cycles → no pulses, all counts 0.
- Drive sig_in[0] 0→1 at edge k → pos_pulse[0] high only in the cycle after edge k+2; pos_count[0]=1 in that same cycle. 1→0 later → neg_count[0]=1.
- Toggle sig_in[2] every cycle for 20 cycles → 10 pos and 10 neg pulses, alternating; counts 10/10; other channels stay 0.
- SATURATE=0, CNT_W=4: 17 rising edges on ch1 → pos_count[1]=1, overflow[1]=1. SATURATE=1: same stimulus → pos_count[1]=15, overflow[1]=1.
- Counts at 5: assert clear[3] in the same cycle as a ch3 rising pulse → pos_count[3]=1, neg_count[3]=0, overflow[3]=0. With enable=0, 3 edges → pulses present, counts unchanged.
- With EDGE_DEBOUNCE_EN, DEB_CYCLES=4: a 3-cycle high glitch → no pulse; a 6-cycle high level → exactly one rising pulse, 4 cycles later than without the filter.
